// File: rtl/clint_pkg.sv
// Shared constants and FSM state types for the AXI core-local interruptor.
package clint_pkg;

    localparam int unsigned OFF_W  = 13;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned STRB_W = 8;

    localparam logic [OFF_W-1:0] CLINT_MSIP_OFF     = 13'h0000;
    localparam logic [OFF_W-1:0] CLINT_MTIMECMP_OFF = 13'h0800;
    localparam logic [OFF_W-1:0] CLINT_MTIME_OFF    = 13'h17FF;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } wr_state_t;
    typedef enum logic { R_IDLE, R_DATA } rd_state_t;

    function automatic logic off_valid(input logic [OFF_W-1:0] off);
        return (off == CLINT_MSIP_OFF) || (off == CLINT_MTIMECMP_OFF) ||
               (off == CLINT_MTIME_OFF);
    endfunction

endpackage

// File: rtl/axi_clint_if.sv
// Single-beat AXI4 slave port bundle for the CLINT register block.
interface axi_clint_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              s_awvalid;
    logic              s_awready;
    logic [ADDR_W-1:0] s_awaddr;
    logic [2:0]        s_awsize;
    logic              s_wvalid;
    logic              s_wready;
    logic [63:0]       s_wdata;
    logic [7:0]        s_wstrb;
    logic              s_wlast;
    logic              s_bvalid;
    logic              s_bready;
    logic [1:0]        s_bresp;
    logic              s_arvalid;
    logic              s_arready;
    logic [ADDR_W-1:0] s_araddr;
    logic [2:0]        s_arsize;
    logic              s_rvalid;
    logic              s_rready;
    logic [63:0]       s_rdata;
    logic [1:0]        s_rresp;
    logic              s_rlast;

    modport master (
        output s_awvalid, s_awaddr, s_awsize, s_wvalid, s_wdata, s_wstrb, s_wlast,
               s_bready, s_arvalid, s_araddr, s_arsize, s_rready,
        input  s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid,
               s_rdata, s_rresp, s_rlast
    );

    modport slave (
        input  s_awvalid, s_awaddr, s_awsize, s_wvalid, s_wdata, s_wstrb, s_wlast,
               s_bready, s_arvalid, s_araddr, s_arsize, s_rready,
        output s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid,
               s_rdata, s_rresp, s_rlast
    );
endinterface

// File: rtl/clint_timebase.sv
// Prescaled 64-bit machine timer with a byte-strobed write port.
module clint_timebase
    import clint_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [STRB_W-1:0] wr_strb,
    output logic [DATA_W-1:0] mtime,
    output logic              tick_c
);
    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0]  pre_q;
    logic [DATA_W-1:0] mtime_n;

    assign tick_c = (pre_q == PRE_MAX);

    // Written bytes override the incremented value; unwritten bytes keep the tick.
    always_comb begin
        mtime_n = tick_c ? (mtime + 64'd1) : mtime;
        for (int i = 0; i < STRB_W; i++) begin
            if (wr_en && wr_strb[i]) mtime_n[i*8 +: 8] = wr_data[i*8 +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_q <= '0;
            mtime <= '0;
        end else begin
            pre_q <= tick_c ? '0 : pre_q + PRE_W'(1);
            mtime <= mtime_n;
        end
    end
endmodule

// File: rtl/axi_clint.sv
// AXI4 core-local interruptor: msip, mtimecmp and mtime with timer/software interrupts.
module axi_clint
    import clint_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    axi_clint_if.slave        s,
    output logic [DATA_W-1:0] mtime,
    output logic              irq_m_timer,
    output logic              irq_m_software
);
    wr_state_t         w_state_q, w_state_n;
    logic              aw_lat_q, aw_lat_n, w_lat_q, w_lat_n;
    logic [OFF_W-1:0]  aw_off_q, aw_off_n;
    logic [DATA_W-1:0] wdata_q, wdata_n;
    logic [STRB_W-1:0] wstrb_q, wstrb_n;
    logic              awready_q, awready_n, wready_q, wready_n;
    logic              bvalid_q, bvalid_n;
    logic [1:0]        bresp_q, bresp_n;

    rd_state_t         r_state_q, r_state_n;
    logic              arready_q, arready_n, rvalid_q, rvalid_n;
    logic [DATA_W-1:0] rdata_q, rdata_n, rd_data_c;
    logic [1:0]        rresp_q, rresp_n, rd_resp_c;

    logic [DATA_W-1:0] mtimecmp_q;
    logic              msip_q;
    logic              aw_hs_c, w_hs_c, ar_hs_c, aw_have_c, w_have_c, commit_c;
    logic [OFF_W-1:0]  wr_off_c, rd_off_c;
    logic [DATA_W-1:0] wr_data_c;
    logic [STRB_W-1:0] wr_strb_c;
    logic              tick_c, unused_c;

    assign unused_c = ^{s.s_awsize, s.s_arsize, s.s_wlast, s.s_awaddr[ADDR_W-1:16],
                        s.s_awaddr[2:0], s.s_araddr[ADDR_W-1:16], s.s_araddr[2:0], tick_c};

    assign s.s_awready = awready_q;
    assign s.s_wready  = wready_q;
    assign s.s_bvalid  = bvalid_q;
    assign s.s_bresp   = bresp_q;
    assign s.s_arready = arready_q;
    assign s.s_rvalid  = rvalid_q;
    assign s.s_rdata   = rdata_q;
    assign s.s_rresp   = rresp_q;
    assign s.s_rlast   = rvalid_q;

    // Merge latched and same-cycle AW/W beats into one write command.
    assign aw_hs_c   = s.s_awvalid & awready_q;
    assign w_hs_c    = s.s_wvalid & wready_q;
    assign aw_have_c = aw_lat_q | aw_hs_c;
    assign w_have_c  = w_lat_q | w_hs_c;
    assign commit_c  = (w_state_q == W_IDLE) && aw_have_c && w_have_c;
    assign wr_off_c  = aw_lat_q ? aw_off_q : s.s_awaddr[15:3];
    assign wr_data_c = w_lat_q ? wdata_q : s.s_wdata;
    assign wr_strb_c = w_lat_q ? wstrb_q : s.s_wstrb;

    always_comb begin
        w_state_n = w_state_q;
        aw_lat_n  = aw_lat_q;
        w_lat_n   = w_lat_q;
        aw_off_n  = aw_off_q;
        wdata_n   = wdata_q;
        wstrb_n   = wstrb_q;
        awready_n = awready_q;
        wready_n  = wready_q;
        bvalid_n  = bvalid_q;
        bresp_n   = bresp_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs_c) begin
                    aw_lat_n = 1'b1;
                    aw_off_n = s.s_awaddr[15:3];
                end
                if (w_hs_c) begin
                    w_lat_n = 1'b1;
                    wdata_n = s.s_wdata;
                    wstrb_n = s.s_wstrb;
                end
                awready_n = !aw_have_c;
                wready_n  = !w_have_c;
                if (commit_c) begin
                    w_state_n = W_RESP;
                    aw_lat_n  = 1'b0;
                    w_lat_n   = 1'b0;
                    awready_n = 1'b0;
                    wready_n  = 1'b0;
                    bvalid_n  = 1'b1;
                    bresp_n   = off_valid(wr_off_c) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                end
            end
            W_RESP: begin
                if (s.s_bready) begin
                    w_state_n = W_IDLE;
                    bvalid_n  = 1'b0;
                    bresp_n   = AXI_RESP_OKAY;
                    awready_n = 1'b1;
                    wready_n  = 1'b1;
                end
            end
            default: w_state_n = W_IDLE;
        endcase
    end

    // Read decode samples register state before any same-cycle write lands.
    assign rd_off_c = s.s_araddr[15:3];
    assign ar_hs_c  = s.s_arvalid & arready_q;

    always_comb begin
        rd_data_c = '0;
        rd_resp_c = AXI_RESP_OKAY;
        case (rd_off_c)
            CLINT_MSIP_OFF:     rd_data_c = {63'd0, msip_q};
            CLINT_MTIMECMP_OFF: rd_data_c = mtimecmp_q;
            CLINT_MTIME_OFF:    rd_data_c = mtime;
            default:            rd_resp_c = AXI_RESP_SLVERR;
        endcase
    end

    always_comb begin
        r_state_n = r_state_q;
        arready_n = arready_q;
        rvalid_n  = rvalid_q;
        rdata_n   = rdata_q;
        rresp_n   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                arready_n = 1'b1;
                if (ar_hs_c) begin
                    r_state_n = R_DATA;
                    arready_n = 1'b0;
                    rvalid_n  = 1'b1;
                    rdata_n   = rd_data_c;
                    rresp_n   = rd_resp_c;
                end
            end
            R_DATA: begin
                if (s.s_rready) begin
                    r_state_n = R_IDLE;
                    arready_n = 1'b1;
                    rvalid_n  = 1'b0;
                    rdata_n   = '0;
                    rresp_n   = AXI_RESP_OKAY;
                end
            end
            default: r_state_n = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_state_q <= W_IDLE;
            aw_lat_q  <= 1'b0;
            w_lat_q   <= 1'b0;
            aw_off_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= AXI_RESP_OKAY;
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= AXI_RESP_OKAY;
        end else begin
            w_state_q <= w_state_n;
            aw_lat_q  <= aw_lat_n;
            w_lat_q   <= w_lat_n;
            aw_off_q  <= aw_off_n;
            wdata_q   <= wdata_n;
            wstrb_q   <= wstrb_n;
            awready_q <= awready_n;
            wready_q  <= wready_n;
            bvalid_q  <= bvalid_n;
            bresp_q   <= bresp_n;
            r_state_q <= r_state_n;
            arready_q <= arready_n;
            rvalid_q  <= rvalid_n;
            rdata_q   <= rdata_n;
            rresp_q   <= rresp_n;
        end
    end

    // Compare and software registers plus registered interrupt outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mtimecmp_q     <= '1;
            msip_q         <= 1'b0;
            irq_m_timer    <= 1'b0;
            irq_m_software <= 1'b0;
        end else begin
            if (commit_c && (wr_off_c == CLINT_MTIMECMP_OFF)) begin
                for (int i = 0; i < STRB_W; i++) begin
                    if (wr_strb_c[i]) mtimecmp_q[i*8 +: 8] <= wr_data_c[i*8 +: 8];
                end
            end
            if (commit_c && (wr_off_c == CLINT_MSIP_OFF) && wr_strb_c[0]) begin
                msip_q <= wr_data_c[0];
            end
            irq_m_timer    <= (mtime >= mtimecmp_q);
            irq_m_software <= msip_q;
        end
    end

    clint_timebase #(
        .TICK_DIV (TICK_DIV)
    ) u_timebase (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (commit_c && (wr_off_c == CLINT_MTIME_OFF)),
        .wr_data (wr_data_c),
        .wr_strb (wr_strb_c),
        .mtime   (mtime),
        .tick_c  (tick_c)
    );
endmodule

// File: tb/tb_axi_clint.sv
// Directed bench for axi_clint: a TICK_DIV=100 instance plus a TICK_DIV=1 instance for wrap.
module tb_axi_clint;
    import clint_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    axi_clint_if #(.ADDR_W(32)) bus ();
    axi_clint_if #(.ADDR_W(32)) bus2 ();

    logic [63:0] mtime, mtime2;
    logic        irq_t, irq_s, irq_t2, irq_s2;

    axi_clint #(.TICK_DIV(100), .ADDR_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .s(bus),
        .mtime(mtime), .irq_m_timer(irq_t), .irq_m_software(irq_s)
    );

    axi_clint #(.TICK_DIV(1), .ADDR_W(32)) dut2 (
        .clk(clk), .reset_n(reset_n), .s(bus2),
        .mtime(mtime2), .irq_m_timer(irq_t2), .irq_m_software(irq_s2)
    );

    int ncmp = 0;
    int nfail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input string tag, input logic [31:0] a, input logic [63:0] d,
                             input logic [7:0] st, input logic [1:0] exp_resp);
        int n;
        @(negedge clk);
        bus.s_awvalid = 1'b1; bus.s_awaddr = a; bus.s_awsize = 3'd3;
        bus.s_wvalid  = 1'b1; bus.s_wdata  = d; bus.s_wstrb  = st; bus.s_wlast = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
        n = 0;
        while (!bus.s_bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_bvalid"}, 64'(bus.s_bvalid), 64'd1);
        check({tag, "_bresp"}, 64'(bus.s_bresp), 64'(exp_resp));
        bus.s_bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.s_bready = 1'b0;
    endtask

    task automatic axi_read(input string tag, input logic [31:0] a, input logic [63:0] exp_data,
                            input logic [1:0] exp_resp, input int hold);
        int n;
        @(negedge clk);
        bus.s_arvalid = 1'b1; bus.s_araddr = a; bus.s_arsize = 3'd3;
        @(posedge clk);
        @(negedge clk);
        bus.s_arvalid = 1'b0;
        n = 0;
        while (!bus.s_rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_rdata"}, bus.s_rdata, exp_data);
        check({tag, "_rresp"}, 64'(bus.s_rresp), 64'(exp_resp));
        check({tag, "_rlast"}, 64'(bus.s_rlast), 64'd1);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check({tag, "_hold_rvalid"}, 64'(bus.s_rvalid), 64'd1);
            check({tag, "_hold_rdata"}, bus.s_rdata, exp_data);
        end
        bus.s_rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.s_rready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] prev;
        int n;
        bus.s_awvalid = 0; bus.s_awaddr = 0; bus.s_awsize = 0; bus.s_wvalid = 0;
        bus.s_wdata = 0; bus.s_wstrb = 0; bus.s_wlast = 0; bus.s_bready = 0;
        bus.s_arvalid = 0; bus.s_araddr = 0; bus.s_arsize = 0; bus.s_rready = 0;
        bus2.s_awvalid = 0; bus2.s_awaddr = 0; bus2.s_awsize = 0; bus2.s_wvalid = 0;
        bus2.s_wdata = 0; bus2.s_wstrb = 0; bus2.s_wlast = 0; bus2.s_bready = 0;
        bus2.s_arvalid = 0; bus2.s_araddr = 0; bus2.s_arsize = 0; bus2.s_rready = 0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #3;
        check("rst_awready", 64'(bus.s_awready), 64'd0);
        check("rst_wready", 64'(bus.s_wready), 64'd0);
        check("rst_arready", 64'(bus.s_arready), 64'd0);
        check("rst_bvalid", 64'(bus.s_bvalid), 64'd0);
        check("rst_rvalid", 64'(bus.s_rvalid), 64'd0);
        check("rst_rdata", bus.s_rdata, 64'd0);
        check("rst_mtime", mtime, 64'd0);
        check("rst_irq_t", 64'(irq_t), 64'd0);
        check("rst_irq_s", 64'(irq_s), 64'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Idle 1000 cycles: ten ticks at TICK_DIV=100, one per cycle at TICK_DIV=1.
        repeat (1000) @(negedge clk);
        check("idle_mtime", mtime, 64'd10);
        check("idle_mtime_div1", mtime2, 64'd1000);
        check("idle_irq_t", 64'(irq_t), 64'd0);
        check("idle_awready", 64'(bus.s_awready), 64'd1);
        check("idle_wready", 64'(bus.s_wready), 64'd1);
        check("idle_arready", 64'(bus.s_arready), 64'd1);
        check("idle_bvalid", 64'(bus.s_bvalid), 64'd0);

        // Timer compare: irq rises one cycle after mtime reaches 20.
        axi_write("cmp20", 32'h4000, 64'd20, 8'hFF, AXI_RESP_OKAY);
        n = 0;
        while (mtime != 64'd20 && n < 1500) begin
            @(negedge clk);
            n++;
        end
        check("cmp_reach20", mtime, 64'd20);
        check("cmp_irq_lag", 64'(irq_t), 64'd0);
        @(negedge clk);
        check("cmp_irq_set", 64'(irq_t), 64'd1);
        axi_write("cmp1000", 32'h4000, 64'd1000, 8'hFF, AXI_RESP_OKAY);
        check("cmp_irq_clr", 64'(irq_t), 64'd0);
        axi_read("rd_cmp", 32'h4000, 64'd1000, AXI_RESP_OKAY, 0);

        // W beat three cycles ahead of AW, targeting msip.
        @(negedge clk);
        bus.s_wvalid = 1'b1; bus.s_wdata = 64'd1; bus.s_wstrb = 8'h01; bus.s_wlast = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.s_wvalid = 1'b0;
        check("wfirst_wready", 64'(bus.s_wready), 64'd0);
        check("wfirst_awready", 64'(bus.s_awready), 64'd1);
        repeat (2) @(negedge clk);
        check("wfirst_no_b", 64'(bus.s_bvalid), 64'd0);
        bus.s_awvalid = 1'b1; bus.s_awaddr = 32'h0000;
        @(posedge clk);
        @(negedge clk);
        bus.s_awvalid = 1'b0;
        check("wfirst_bvalid", 64'(bus.s_bvalid), 64'd1);
        check("wfirst_bresp", 64'(bus.s_bresp), 64'(AXI_RESP_OKAY));
        check("wfirst_awready_resp", 64'(bus.s_awready), 64'd0);
        bus.s_bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.s_bready = 1'b0;
        check("wfirst_b_single", 64'(bus.s_bvalid), 64'd0);
        check("msip_irq", 64'(irq_s), 64'd1);
        axi_read("rd_msip", 32'h0000, 64'd1, AXI_RESP_OKAY, 0);

        // Upper-half mtime write landing on the same edge as the 5 -> 6 tick.
        axi_write("mt3", 32'hBFF8, 64'd3, 8'hFF, AXI_RESP_OKAY);
        prev = mtime;
        n = 0;
        while (!(prev == 64'd4 && mtime == 64'd5) && n < 300) begin
            prev = mtime;
            @(negedge clk);
            n++;
        end
        check("mt_at5", mtime, 64'd5);
        repeat (98) @(negedge clk);
        axi_write("mt_hi", 32'hBFF8, 64'h0000_0001_0000_0000, 8'hF0, AXI_RESP_OKAY);
        check("mt_merge", mtime, 64'h0000_0001_0000_0006);

        // Unmapped offsets, with rready held low for five cycles.
        axi_read("rd_bad", 32'h1000, 64'd0, AXI_RESP_SLVERR, 5);
        axi_write("wr_bad", 32'h2000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, AXI_RESP_SLVERR);
        axi_read("rd_cmp_keep", 32'h4000, 64'd1000, AXI_RESP_OKAY, 0);
        axi_read("rd_msip_keep", 32'h0000, 64'd1, AXI_RESP_OKAY, 0);
        check("mt_keep_hi", 64'(mtime[63:32]), 64'd1);
        check("irq_t_big", 64'(irq_t), 64'd1);

        // Same-cycle read and write of mtimecmp: read sees the old value.
        @(negedge clk);
        bus.s_arvalid = 1'b1; bus.s_araddr = 32'h4000;
        bus.s_awvalid = 1'b1; bus.s_awaddr = 32'h4000;
        bus.s_wvalid = 1'b1; bus.s_wdata = 64'd2000; bus.s_wstrb = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        bus.s_arvalid = 1'b0; bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
        check("rw_old_rdata", bus.s_rdata, 64'd1000);
        check("rw_bvalid", 64'(bus.s_bvalid), 64'd1);
        bus.s_rready = 1'b1; bus.s_bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.s_rready = 1'b0; bus.s_bready = 1'b0;
        axi_read("rd_cmp_new", 32'h4000, 64'd2000, AXI_RESP_OKAY, 0);

        // TICK_DIV=1 instance: written all-ones, wraps to zero on the next edge.
        @(negedge clk);
        bus2.s_awvalid = 1'b1; bus2.s_awaddr = 32'hBFF8;
        bus2.s_wvalid = 1'b1; bus2.s_wdata = 64'hFFFF_FFFF_FFFF_FFFF; bus2.s_wstrb = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        bus2.s_awvalid = 1'b0; bus2.s_wvalid = 1'b0;
        check("div1_allones", mtime2, 64'hFFFF_FFFF_FFFF_FFFF);
        check("div1_bvalid", 64'(bus2.s_bvalid), 64'd1);
        @(negedge clk);
        check("div1_wrap", mtime2, 64'd0);
        bus2.s_bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus2.s_bready = 1'b0;

        // Reset asserted while a write response is pending.
        bus.s_awvalid = 1'b1; bus.s_awaddr = 32'h4000;
        bus.s_wvalid = 1'b1; bus.s_wdata = 64'd5; bus.s_wstrb = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
        check("mid_bvalid", 64'(bus.s_bvalid), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_bvalid", 64'(bus.s_bvalid), 64'd0);
        check("mid_rst_awready", 64'(bus.s_awready), 64'd0);
        check("mid_rst_mtime", mtime, 64'd0);
        check("mid_rst_irq_t", 64'(irq_t), 64'd0);
        check("mid_rst_irq_s", 64'(irq_s), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        axi_read("rst_cmp", 32'h4000, 64'hFFFF_FFFF_FFFF_FFFF, AXI_RESP_OKAY, 0);
        axi_read("rst_msip", 32'h0000, 64'd0, AXI_RESP_OKAY, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/axi_clint.md
Name: axi_clint

Overview:
- Core-local interruptor on the CPU's cacheless peripheral AXI4 port, downstream of the core.
- Holds the 64-bit machine timer (mtime), the timer compare register (mtimecmp) and the software-interrupt bit (msip).
- Feeds the core's rdtime input and its machine timer/software interrupt inputs.
- Replaces the free-running tick counter in the CPU wrapper.

Parameters:
- TICK_DIV, 100, clk cycles per mtime increment (100 MHz clk -> 1 MHz timebase); legal range >= 1.
- ADDR_W, 32, AXI address width; only addr[15:0] is decoded, base decode belongs to the interconnect.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- s_awvalid  in  1  write address valid
- s_awready  out  1  write address ready
- s_awaddr  in  ADDR_W  write address
- s_awsize  in  3  write size (ignored, strobes govern)
- s_wvalid  in  1  write data valid
- s_wready  out  1  write data ready
- s_wdata  in  64  write data
- s_wstrb  in  8  byte strobes
- s_wlast  in  1  ignored, always single beat
- s_bvalid  out  1  write response valid
- s_bready  in  1  write response ready
- s_bresp  out  2  OKAY 2'b00 / SLVERR 2'b10
- s_arvalid  in  1  read address valid
- s_arready  out  1  read address ready
- s_araddr  in  ADDR_W  read address
- s_arsize  in  3  read size (ignored)
- s_rvalid  out  1  read data valid
- s_rready  in  1  read data ready
- s_rdata  out  64  read data
- s_rresp  out  2  OKAY / SLVERR
- s_rlast  out  1  tied 1 while s_rvalid
- mtime  out  64  current timer value, to core rdtime
- irq_m_timer  out  1  machine timer interrupt
- irq_m_software  out  1  machine software interrupt

Behaviour:
- Reset (reset_n low, async), all values below take effect immediately:
  - mtime=0, prescaler=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0.
  - All valid/ready outputs 0, bresp/rresp=0, rdata=0, irq outputs 0.
- Register map (offset = addr[15:3], 8-byte aligned; addr[2:0] ignored):
  - 0x0000 msip: bit0 RW, other bits read 0.
  - 0x4000 mtimecmp: RW 64-bit.
  - 0xBFF8 mtime: RW 64-bit.
  - Any other offset: reads return 0 with SLVERR; writes are dropped with SLVERR.
- Byte strobes apply per lane on writes, so a 32-bit access to either half works. msip uses wstrb[0] only.
- Prescaler:
  - Counts 0..TICK_DIV-1; mtime increments on the cycle the prescaler wraps.
  - TICK_DIV=1 increments mtime every cycle.
  - mtime wraps 2^64-1 -> 0 with no flag.
- Simultaneous mtime write and tick: the written bytes win and unwritten bytes take the incremented value. The prescaler is not reset by an mtime write.
- irq_m_timer is registered: (mtime >= mtimecmp), unsigned, evaluated on current register values, so one cycle of latency after any change. Deasserts the cycle after a mtimecmp write raises the compare above mtime.
- irq_m_software is registered copy of msip.
- Write channel FSM:
  - W_IDLE: awready=1 and wready=1. AW and W are accepted independently and each is latched; a channel already latched drops its ready.
  - When both are latched (same cycle or different cycles) -> W_RESP. The write commits on that transition edge, then bvalid=1.
  - W_RESP: hold bvalid and bresp until bready, then -> W_IDLE. awready and wready stay 0 in W_RESP.
- Read channel FSM:
  - R_IDLE: arready=1. On handshake, decode and register rdata/rresp, then -> R_DATA with rvalid=1 the next cycle (1-cycle latency), rlast=1.
  - R_DATA: arready=0; hold rdata/rresp stable until rready, then -> R_IDLE.
  - Read data is the value sampled at the AR handshake cycle.
- Read and write channels are independent. A read and a write of the same register in the same cycle: the read returns the old value.
- No outstanding depth beyond 1 per channel. No bursts: AXI_DP carries no len field.

Decomposition:
- Shared package clint_pkg:
  - Offset constants CLINT_MSIP_OFF, CLINT_MTIMECMP_OFF, CLINT_MTIME_OFF.
  - AXI resp constants AXI_RESP_OKAY, AXI_RESP_SLVERR.
  - State enum types for the write and read FSMs.
- One sub-module, clint_timebase: prescaler, mtime register with per-byte write port, tick output.
- The AXI FSMs and decode stay in axi_clint.
- The CPU wrapper instantiates axi_clint on the DP port path and drives rdtime and the interrupt inputs from it.

Test Plan:
- Reset then idle 1000 cycles, TICK_DIV=100 -> mtime=10, irq_m_timer=0, all readies as specified.
- Write mtimecmp=64'd20 (wstrb=8'hFF) -> bresp=OKAY; irq_m_timer rises one cycle after mtime reaches 20; writing mtimecmp=64'd1000 clears it next cycle.
- W beat presented 3 cycles before AW -> wready drops after W handshake, single bvalid after AW accepted; write to msip=1 -> irq_m_software=1, read 0x0000 returns 64'h1.
- Write mtime upper half only (wstrb=8'hF0, data 64'h0000_0001_0000_0000) coincident with a tick while mtime=5 -> mtime=64'h0000_0001_0000_0006.
- Read 0x1000 and write 0x2000 -> rresp=SLVERR rdata=0, bresp=SLVERR, no register changes; rready held low 5 cycles keeps rdata/rvalid stable.
- Set mtime=64'hFFFF_FFFF_FFFF_FFFF, TICK_DIV=1 -> next cycle mtime=0. Assert reset_n=0 mid-W_RESP -> bvalid=0 immediately, mtimecmp all-ones.
